// File: rtl/conv33_pkg.sv
// Shared definitions for the conv33 window path: default geometry, counter sizing
// and the default-width 3x3 window type.
package conv33_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_IMG_W      = 28;
    localparam int DEF_IMG_H      = 28;

    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Rows x cols, row 0 = oldest row, col 0 = leftmost.
    typedef logic [2:0][2:0][DEF_DATA_WIDTH-1:0] win_t;

endpackage

// File: rtl/conv33_line_buf.sv
// One image row of pixel storage: combinational read and synchronous write at the
// same column address. Contents are never cleared; row gating masks stale data.
module conv33_line_buf
    import conv33_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_IMG_W
) (
    input  logic                        clk,
    input  logic                        we,
    input  logic [cnt_w(DEPTH)-1:0]     addr,
    input  logic [DATA_WIDTH-1:0]       wdata,
    output logic [DATA_WIDTH-1:0]       rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/conv33_window_gen.sv
// Streaming 3x3 window generator over a raster pixel stream with a ready/valid window
// output. Define CONV33_WIN_STRIDE2_EN to emit only stride-2 aligned windows.
module conv33_window_gen
    import conv33_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int IMG_W      = DEF_IMG_W,
    parameter int IMG_H      = DEF_IMG_H
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pix_valid,
    input  logic [DATA_WIDTH-1:0] pix_data,
    output logic                  pix_ready,
    output logic                  win_valid,
    input  logic                  win_ready,
    output logic [DATA_WIDTH-1:0] win_0_0,
    output logic [DATA_WIDTH-1:0] win_0_1,
    output logic [DATA_WIDTH-1:0] win_0_2,
    output logic [DATA_WIDTH-1:0] win_1_0,
    output logic [DATA_WIDTH-1:0] win_1_1,
    output logic [DATA_WIDTH-1:0] win_1_2,
    output logic [DATA_WIDTH-1:0] win_2_0,
    output logic [DATA_WIDTH-1:0] win_2_1,
    output logic [DATA_WIDTH-1:0] win_2_2,
    output logic                  win_last
);

    localparam int CW = cnt_w(IMG_W);
    localparam int RW = cnt_w(IMG_H);
`ifdef CONV33_WIN_STRIDE2_EN
    // Last window sits on the final even row/column at or below the image edge.
    localparam int LAST_R = ((IMG_H - 1) / 2) * 2;
    localparam int LAST_C = ((IMG_W - 1) / 2) * 2;
`else
    localparam int LAST_R = IMG_H - 1;
    localparam int LAST_C = IMG_W - 1;
`endif

    logic [CW-1:0]         col_cnt;
    logic [RW-1:0]         row_cnt;
    logic [DATA_WIDTH-1:0] lb0_rd;
    logic [DATA_WIDTH-1:0] lb1_rd;
    logic [DATA_WIDTH-1:0] win [3][3];
    logic                  accept;
    logic                  qualify;
    logic                  at_last;

    assign pix_ready = !(win_valid && !win_ready);
    assign accept    = pix_valid && pix_ready;

    always_comb begin
        qualify = (row_cnt >= RW'(2)) && (col_cnt >= CW'(2));
`ifdef CONV33_WIN_STRIDE2_EN
        qualify = qualify && !row_cnt[0] && !col_cnt[0];
`endif
        at_last = (row_cnt == RW'(LAST_R)) && (col_cnt == CW'(LAST_C));
    end

    // lb0 carries row r-1; its read value cascades into lb1 (row r-2).
    conv33_line_buf #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_W)) u_lb0 (
        .clk   (clk),
        .we    (accept),
        .addr  (col_cnt),
        .wdata (pix_data),
        .rdata (lb0_rd)
    );

    conv33_line_buf #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_W)) u_lb1 (
        .clk   (clk),
        .we    (accept),
        .addr  (col_cnt),
        .wdata (lb0_rd),
        .rdata (lb1_rd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            col_cnt   <= '0;
            row_cnt   <= '0;
            win_valid <= 1'b0;
            win_last  <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    win[i][j] <= '0;
                end
            end
        end else if (accept) begin
            if (col_cnt == CW'(IMG_W - 1)) begin
                col_cnt <= '0;
                row_cnt <= (row_cnt == RW'(IMG_H - 1)) ? '0 : row_cnt + RW'(1);
            end else begin
                col_cnt <= col_cnt + CW'(1);
            end
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 2; j++) begin
                    win[i][j] <= win[i][j+1];
                end
            end
            win[0][2] <= lb1_rd;
            win[1][2] <= lb0_rd;
            win[2][2] <= pix_data;
            win_valid <= qualify;
            win_last  <= qualify && at_last;
        end else if (win_ready) begin
            win_valid <= 1'b0;
            win_last  <= 1'b0;
        end
    end

    assign win_0_0 = win[0][0];
    assign win_0_1 = win[0][1];
    assign win_0_2 = win[0][2];
    assign win_1_0 = win[1][0];
    assign win_1_1 = win[1][1];
    assign win_1_2 = win[1][2];
    assign win_2_0 = win[2][0];
    assign win_2_1 = win[2][1];
    assign win_2_2 = win[2][2];

endmodule

// File: tb/tb_conv33_window_gen.sv
// Directed bench for conv33_window_gen on a 5x5 ramp image, checking every cycle
// against a pixel-position model of the expected windows.
module tb_conv33_window_gen;

    localparam int W  = 5;
    localparam int H  = 5;
    localparam int DW = 8;
`ifdef CONV33_WIN_STRIDE2_EN
    localparam int NWIN = ((W - 1) / 2) * ((H - 1) / 2);
`else
    localparam int NWIN = (W - 2) * (H - 2);
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          pix_valid;
    logic [DW-1:0] pix_data;
    logic          pix_ready;
    logic          win_valid;
    logic          win_ready;
    logic          win_last;
    logic [DW-1:0] w00, w01, w02, w10, w11, w12, w20, w21, w22;
    logic [71:0]   dut_win;

    assign dut_win = {w00, w01, w02, w10, w11, w12, w20, w21, w22};

    always #5 clk = ~clk;

    conv33_window_gen #(.DATA_WIDTH(DW), .IMG_W(W), .IMG_H(H)) dut (
        .clk       (clk),
        .rst       (rst),
        .pix_valid (pix_valid),
        .pix_data  (pix_data),
        .pix_ready (pix_ready),
        .win_valid (win_valid),
        .win_ready (win_ready),
        .win_0_0   (w00),
        .win_0_1   (w01),
        .win_0_2   (w02),
        .win_1_0   (w10),
        .win_1_1   (w11),
        .win_1_2   (w12),
        .win_2_0   (w20),
        .win_2_1   (w21),
        .win_2_2   (w22),
        .win_last  (win_last)
    );

    int checks   = 0;
    int failures = 0;

    // Expected windows pending on the output: {first, last, window}.
    logic [73:0] q[$];
    int          mr = 0;
    int          mc = 0;
    int          ntaken = 0;
    int          nlast  = 0;
    int          stall_left = 0;
    logic [71:0] first_win = '0;
    logic [71:0] last_win  = '0;

    task automatic check(input string tag, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic bit qual(input int r, input int c);
`ifdef CONV33_WIN_STRIDE2_EN
        return (r >= 2) && (c >= 2) && (r % 2 == 0) && (c % 2 == 0);
`else
        return (r >= 2) && (c >= 2);
`endif
    endfunction

    function automatic bit is_last(input int r, input int c);
`ifdef CONV33_WIN_STRIDE2_EN
        return (r == ((H - 1) / 2) * 2) && (c == ((W - 1) / 2) * 2);
`else
        return (r == H - 1) && (c == W - 1);
`endif
    endfunction

    function automatic logic [71:0] exp_win(input int base, input int r, input int c);
        logic [71:0] v = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                v = {v[63:0], 8'(base + (r - 2 + i) * W + (c - 2 + j))};
            end
        end
        return v;
    endfunction

    task automatic cycle(input bit pv, input logic [DW-1:0] pd, input bit wr,
                         input int base, output bit acc);
        @(negedge clk);
        pix_valid = pv;
        pix_data  = pd;
        win_ready = wr;
        #1;
        check("win_valid", win_valid, q.size() != 0);
        check("pix_ready", pix_ready, !(q.size() != 0 && !wr));
        if (win_valid && q.size() != 0) begin
            check("window", dut_win, q[0][71:0]);
            check("win_last", win_last, q[0][72]);
            if (wr) begin
                if (q[0][73]) first_win = dut_win;
                if (win_last) last_win = dut_win;
                ntaken++;
                nlast += int'(win_last);
                void'(q.pop_front());
            end
        end
        acc = pv && pix_ready;
        @(posedge clk);
        if (acc) begin
            if (qual(mr, mc))
                q.push_back({(mr == 2 && mc == 2), is_last(mr, mc), exp_win(base, mr, mc)});
            if (mc == W - 1) begin
                mc = 0;
                mr = (mr == H - 1) ? 0 : mr + 1;
            end else begin
                mc++;
            end
        end
    endtask

    task automatic drive_frame(input int base, input int npix, input bit rnd);
        int  idx = 0;
        int  budget = 400;
        bit  pv, wr, acc;
        while (idx < npix && budget > 0) begin
            pv = rnd ? ($urandom_range(1) == 1) : 1'b1;
            wr = rnd ? ($urandom_range(3) != 0) : 1'b1;
            if (stall_left > 0 && q.size() != 0) begin
                wr = 1'b0;
                stall_left--;
            end
            cycle(pv, 8'(base + idx), wr, base, acc);
            if (acc) idx++;
            budget--;
        end
        if (idx < npix) check("frame_timeout", idx, npix);
    endtask

    task automatic drain();
        bit acc;
        for (int k = 0; k < 20 && q.size() != 0; k++) begin
            cycle(1'b0, '0, 1'b1, 0, acc);
        end
        check("drain_empty", q.size(), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        pix_valid = 1'b0;
        win_ready = 1'b0;
        @(negedge clk);
        #1;
        check("rst_win_valid", win_valid, 0);
        check("rst_win_last", win_last, 0);
        check("rst_window", dut_win, 0);
        check("rst_pix_ready", pix_ready, 1);
        rst = 1'b0;
        q.delete();
        mr = 0;
        mc = 0;
    endtask

    initial begin
        rst       = 1'b1;
        pix_valid = 1'b0;
        pix_data  = '0;
        win_ready = 1'b1;
        repeat (2) @(posedge clk);
        do_reset();

        // Plain ramp frame, always ready.
        drive_frame(0, W * H, 1'b0);
        drain();
        check("first_win_a", first_win, {8'd0, 8'd1, 8'd2, 8'd5, 8'd6, 8'd7, 8'd10, 8'd11, 8'd12});
        check("last_win_a", last_win, {8'd12, 8'd13, 8'd14, 8'd17, 8'd18, 8'd19, 8'd22, 8'd23, 8'd24});

        // Downstream stall of 3 cycles on the first window.
        stall_left = 3;
        drive_frame(0, W * H, 1'b0);
        drain();
        check("stall_consumed", stall_left, 0);

        // Back-to-back frames with no gap.
        drive_frame(0, W * H, 1'b0);
        drive_frame(100, W * H, 1'b0);
        drain();
        check("first_win_b2b", first_win,
              {8'd100, 8'd101, 8'd102, 8'd105, 8'd106, 8'd107, 8'd110, 8'd111, 8'd112});
        check("last_win_b2b", last_win,
              {8'd112, 8'd113, 8'd114, 8'd117, 8'd118, 8'd119, 8'd122, 8'd123, 8'd124});

        // Reset after pixel 13 of a frame, then a fresh frame.
        drive_frame(0, 14, 1'b0);
        do_reset();
        drive_frame(50, W * H, 1'b0);
        drain();
        check("first_win_rst", first_win,
              {8'd50, 8'd51, 8'd52, 8'd55, 8'd56, 8'd57, 8'd60, 8'd61, 8'd62});

        // Random input gaps and downstream back-pressure.
        drive_frame(30, W * H, 1'b1);
        drain();

        // Six complete frames plus the one window taken before the mid-frame reset.
        check("n_windows", ntaken, 6 * NWIN + 1);
        check("n_last", nlast, 6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
